// File: rtl/hazard_controller.sv
// Load-use hazard controller: stalls decode while a dependent load is in flight.
// Optional HAZARD_STATS_EN macro enables the STALL_CYCLES statistics counter.
module hazard_controller #(
  parameter int unsigned CNT_W   = 4,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [15:0] BUS,
  input  logic [3:0]  LD_reg,
  input  logic [5:0]  SEL_id,
  input  logic        MEM_LD_ex,
  input  logic [3:0]  LD_reg_ex,
  input  logic        MEM_RDY,
  input  logic        FLUSH,
  output logic [15:0] BUS_past,
  output logic [3:0]  LD_reg_past,
  output logic        STALL,
  output logic        ERR,
  output logic [15:0] STALL_CYCLES
);

  typedef enum logic [1:0] {StIdle, StWaitMem, StError} state_e;

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(TIMEOUT - 1);

  state_e           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_pend_reg;
  logic [15:0]      r_bus_past;
  logic [3:0]       r_ld_reg_past;
  logic             r_err;

  logic [3:0] w_y0_oh;
  logic [3:0] w_y1_oh;
  logic       w_hazard;
  logic       w_done;
  logic       w_stall;

  // Codes 4-7 are non-register sources and map to no destination.
  function automatic logic [3:0] src_onehot(input logic [2:0] code);
    return code[2] ? 4'b0000 : (4'b1000 >> code[1:0]);
  endfunction

  assign w_y0_oh  = src_onehot(SEL_id[5:3]);
  assign w_y1_oh  = src_onehot(SEL_id[2:0]);
  assign w_hazard = MEM_LD_ex && (LD_reg_ex != 4'b0000) &&
                    ((w_y0_oh == LD_reg_ex) || (w_y1_oh == LD_reg_ex));
  assign w_done   = MEM_RDY && (LD_reg == r_pend_reg);

  always_comb begin
    w_stall = 1'b0;
    unique case (r_state)
      StIdle:    w_stall = w_hazard && !FLUSH;
      StWaitMem: w_stall = !w_done && !FLUSH;
      StError:   w_stall = 1'b1;
      default:   w_stall = 1'b0;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state       <= StIdle;
      r_cnt         <= '0;
      r_pend_reg    <= 4'b0000;
      r_bus_past    <= 16'h0000;
      r_ld_reg_past <= 4'b0000;
      r_err         <= 1'b0;
    end else begin
      // History keeps advancing even while decode is stalled.
      r_bus_past    <= BUS;
      r_ld_reg_past <= LD_reg;
      unique case (r_state)
        StIdle: begin
          if (w_hazard && !FLUSH) begin
            r_pend_reg <= LD_reg_ex;
            r_cnt      <= '0;
            r_state    <= StWaitMem;
          end
        end
        StWaitMem: begin
          if (w_done || FLUSH) begin
            r_state <= StIdle;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_cnt == CntLast) begin
              r_state <= StError;
              r_err   <= 1'b1;
            end
          end
        end
        StError: r_err <= 1'b1;
        default: r_state <= StIdle;
      endcase
    end
  end

`ifdef HAZARD_STATS_EN
  logic [15:0] r_stall_cycles;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_stall_cycles <= 16'h0000;
    end else if (w_stall && (r_stall_cycles != 16'hFFFF)) begin
      r_stall_cycles <= r_stall_cycles + 16'd1;
    end
  end

  assign STALL_CYCLES = r_stall_cycles;
`else
  assign STALL_CYCLES = 16'h0000;
`endif

  assign BUS_past    = r_bus_past;
  assign LD_reg_past = r_ld_reg_past;
  assign STALL       = w_stall;
  assign ERR         = r_err;

endmodule

// File: tb/tb_hazard_controller.sv
// Directed self-checking bench for hazard_controller (TIMEOUT=15).
module tb_hazard_controller;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [15:0] BUS = 16'h0000;
  logic [3:0]  LD_reg = 4'd0;
  logic [5:0]  SEL_id = 6'o77;
  logic        MEM_LD_ex = 1'b0;
  logic [3:0]  LD_reg_ex = 4'd0;
  logic        MEM_RDY = 1'b0;
  logic        FLUSH = 1'b0;
  logic [15:0] BUS_past;
  logic [3:0]  LD_reg_past;
  logic        STALL;
  logic        ERR;
  logic [15:0] STALL_CYCLES;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_stats = 0;

  hazard_controller #(.CNT_W(4), .TIMEOUT(15)) dut (
    .CLK(CLK), .RST(RST), .BUS(BUS), .LD_reg(LD_reg), .SEL_id(SEL_id),
    .MEM_LD_ex(MEM_LD_ex), .LD_reg_ex(LD_reg_ex), .MEM_RDY(MEM_RDY), .FLUSH(FLUSH),
    .BUS_past(BUS_past), .LD_reg_past(LD_reg_past), .STALL(STALL), .ERR(ERR),
    .STALL_CYCLES(STALL_CYCLES)
  );

  always #5 CLK = ~CLK;

  // Advance to just after the next rising edge, with all inputs quiet.
  task automatic tick_clear();
    @(posedge CLK); #1;
    BUS = 16'h0000; LD_reg = 4'd0; SEL_id = 6'o77; MEM_LD_ex = 1'b0;
    LD_reg_ex = 4'd0; MEM_RDY = 1'b0; FLUSH = 1'b0;
  endtask

  function automatic int stats_exp(input int raw);
`ifdef HAZARD_STATS_EN
    return raw;
`else
    return 0;
`endif
  endfunction

  task automatic test_reset();
    #3;
    n_tests++; if (STALL !== 1'b0) begin n_fail++; $display("FAIL rst_stall: got %b want 0", STALL); end
    n_tests++; if (ERR !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b want 0", ERR); end
    n_tests++; if (BUS_past !== 16'h0000 || LD_reg_past !== 4'd0) begin
      n_fail++; $display("FAIL rst_hist: got %h/%h want 0000/0", BUS_past, LD_reg_past); end
    n_tests++; if (STALL_CYCLES !== 16'h0000) begin
      n_fail++; $display("FAIL rst_stats: got %h want 0000", STALL_CYCLES); end
    @(posedge CLK); #1 RST = 1'b0;
  endtask

  task automatic test_load_use();
    tick_clear();
    MEM_LD_ex = 1'b1; LD_reg_ex = 4'd2; SEL_id = 6'o02; BUS = 16'hA5A5; LD_reg = 4'd4; #1;
    n_tests++; if (STALL !== 1'b1) begin n_fail++; $display("FAIL lu_t0: STALL %b want 1", STALL); end
    tick_clear(); #1;
    n_tests++; if (BUS_past !== 16'hA5A5 || LD_reg_past !== 4'd4) begin
      n_fail++; $display("FAIL hist_stall: got %h/%h want a5a5/4", BUS_past, LD_reg_past); end
    n_tests++; if (STALL !== 1'b1) begin n_fail++; $display("FAIL lu_t1: STALL %b want 1", STALL); end
    tick_clear();
    MEM_RDY = 1'b1; LD_reg = 4'd2; BUS = 16'h1234; #1;
    n_tests++; if (STALL !== 1'b0) begin n_fail++; $display("FAIL lu_t2: STALL %b want 0", STALL); end
    tick_clear(); #1;
    exp_stats += 2;
    n_tests++; if (STALL !== 1'b0 || BUS_past !== 16'h1234 || LD_reg_past !== 4'd2) begin
      n_fail++; $display("FAIL lu_t3: STALL %b past %h/%h want 0 1234/2", STALL, BUS_past, LD_reg_past); end
    n_tests++; if (STALL_CYCLES !== 16'(stats_exp(exp_stats))) begin
      n_fail++; $display("FAIL lu_stats: got %0d want %0d", STALL_CYCLES, stats_exp(exp_stats)); end
  endtask

  task automatic test_no_hazard();
    logic [5:0] sels [4]  = '{6'o74, 6'o74, 6'o02, 6'o47};
    logic       mlds [4]  = '{1'b1, 1'b1, 1'b0, 1'b1};
    logic [3:0] dsts [4]  = '{4'd8, 4'd1, 4'd2, 4'd0};
    for (int i = 0; i < 4; i++) begin
      tick_clear();
      SEL_id = sels[i]; MEM_LD_ex = mlds[i]; LD_reg_ex = dsts[i]; #1;
      n_tests++; if (STALL !== 1'b0) begin
        n_fail++; $display("FAIL nohaz_%0d: STALL %b want 0", i, STALL); end
    end
    tick_clear(); #1;
    n_tests++; if (STALL !== 1'b0) begin n_fail++; $display("FAIL nohaz_idle: STALL %b want 0", STALL); end
  endtask

  task automatic test_wrong_completion();
    tick_clear();
    MEM_LD_ex = 1'b1; LD_reg_ex = 4'd8; SEL_id = 6'o04; #1;
    n_tests++; if (STALL !== 1'b1) begin n_fail++; $display("FAIL wc_t0: STALL %b want 1", STALL); end
    tick_clear();
    MEM_RDY = 1'b1; LD_reg = 4'd1; #1;
    n_tests++; if (STALL !== 1'b1) begin n_fail++; $display("FAIL wc_mismatch: STALL %b want 1", STALL); end
    tick_clear();
    MEM_RDY = 1'b1; LD_reg = 4'd8; #1;
    n_tests++; if (STALL !== 1'b0) begin n_fail++; $display("FAIL wc_match: STALL %b want 0", STALL); end
    tick_clear(); #1;
    exp_stats += 2;
    n_tests++; if (STALL !== 1'b0) begin n_fail++; $display("FAIL wc_after: STALL %b want 0", STALL); end
  endtask

  task automatic test_flush();
    // Flush while waiting, then flush coinciding with completion.
    for (int k = 0; k < 2; k++) begin
      tick_clear();
      MEM_LD_ex = 1'b1; LD_reg_ex = 4'd4; SEL_id = 6'o14; #1;
      n_tests++; if (STALL !== 1'b1) begin n_fail++; $display("FAIL fl%0d_t0: STALL %b want 1", k, STALL); end
      tick_clear();
      FLUSH = 1'b1;
      if (k == 1) begin MEM_RDY = 1'b1; LD_reg = 4'd4; end
      #1;
      n_tests++; if (STALL !== 1'b0) begin n_fail++; $display("FAIL fl%0d_t1: STALL %b want 0", k, STALL); end
      tick_clear(); #1;
      n_tests++; if (STALL !== 1'b0) begin n_fail++; $display("FAIL fl%0d_idle: STALL %b want 0", k, STALL); end
      exp_stats += 1;
    end
    // Flush in IDLE suppresses the hazard and does not enter WAIT_MEM.
    tick_clear();
    MEM_LD_ex = 1'b1; LD_reg_ex = 4'd1; SEL_id = 6'o73; FLUSH = 1'b1; #1;
    n_tests++; if (STALL !== 1'b0) begin n_fail++; $display("FAIL fl_idle_haz: STALL %b want 0", STALL); end
    tick_clear(); #1;
    n_tests++; if (STALL !== 1'b0) begin n_fail++; $display("FAIL fl_idle_next: STALL %b want 0", STALL); end
    n_tests++; if (STALL_CYCLES !== 16'(stats_exp(exp_stats))) begin
      n_fail++; $display("FAIL fl_stats: got %0d want %0d", STALL_CYCLES, stats_exp(exp_stats)); end
  endtask

  task automatic test_timeout_reset();
    int bad = 0;
    tick_clear();
    MEM_LD_ex = 1'b1; LD_reg_ex = 4'd1; SEL_id = 6'o37; #1;
    n_tests++; if (STALL !== 1'b1) begin n_fail++; $display("FAIL to_t0: STALL %b want 1", STALL); end
    for (int i = 1; i <= 15; i++) begin
      tick_clear();
      if (i == 5) begin MEM_RDY = 1'b1; LD_reg = 4'd2; end
      #1;
      if (STALL !== 1'b1 || ERR !== 1'b0) bad++;
    end
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL to_wait: %0d bad cycles want 0", bad); end
    tick_clear(); #1;
    exp_stats += 16;
    n_tests++; if (ERR !== 1'b1 || STALL !== 1'b1) begin
      n_fail++; $display("FAIL to_err: ERR %b STALL %b want 1 1", ERR, STALL); end
    n_tests++; if (STALL_CYCLES !== 16'(stats_exp(exp_stats))) begin
      n_fail++; $display("FAIL to_stats: got %0d want %0d", STALL_CYCLES, stats_exp(exp_stats)); end
    FLUSH = 1'b1; MEM_RDY = 1'b1; LD_reg = 4'd1; BUS = 16'hBEEF; #1;
    n_tests++; if (ERR !== 1'b1 || STALL !== 1'b1) begin
      n_fail++; $display("FAIL err_sticky: ERR %b STALL %b want 1 1", ERR, STALL); end
    @(posedge CLK); #3;
    n_tests++; if (ERR !== 1'b1 || BUS_past !== 16'hBEEF) begin
      n_fail++; $display("FAIL err_hold: ERR %b past %h want 1 beef", ERR, BUS_past); end
    RST = 1'b1; #1;
    n_tests++; if (ERR !== 1'b0 || STALL !== 1'b0 || BUS_past !== 16'h0000 ||
                   LD_reg_past !== 4'd0 || STALL_CYCLES !== 16'h0000) begin
      n_fail++; $display("FAIL async_rst: ERR %b STALL %b past %h/%h stats %h want all 0",
                         ERR, STALL, BUS_past, LD_reg_past, STALL_CYCLES); end
    RST = 1'b0;
    tick_clear(); #1;
    n_tests++; if (STALL !== 1'b0 || ERR !== 1'b0) begin
      n_fail++; $display("FAIL post_rst: ERR %b STALL %b want 0 0", ERR, STALL); end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_no_hazard();
    test_wrong_completion();
    test_flush();
    test_timeout_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_controller.md
# hazard_controller

Load-use hazard controller for the forwarding path. It detects when a decode-stage source operand depends on a memory load still in execute, and stalls decode/fetch with a bubble into execute until the load result reaches the write-back bus. It also registers the write-back history (`BUS_past`, `LD_reg_past`) that the forwarding selector consumes. It sits beside the forwarding selector, between decode and execute.

## Interface
Parameters:
- `CNT_W`, 4: width of the wait counter.
- `TIMEOUT`, 15: number of WAIT_MEM cycles without completion before the block enters ERROR. Legal range is 1 to 2^CNT_W−1.

Ports:
- `CLK` in 1: clock, rising edge.
- `RST` in 1: reset, asynchronous, active-high.
- `BUS` in 16: write-back data this cycle.
- `LD_reg` in 4: one-hot write-back destination. 8=R0, 4=R1, 2=R2, 1=R3, 0=no write.
- `SEL_id` in 6: decode source selects. [5:3] is Y0 and [2:0] is Y1. Codes 0–3 select R0–R3; codes 4–7 are non-register.
- `MEM_LD_ex` in 1: the execute-stage instruction is a memory load.
- `LD_reg_ex` in 4: one-hot destination of the execute-stage instruction.
- `MEM_RDY` in 1: a pending load's data is on `BUS` this cycle.
- `FLUSH` in 1: the decode instruction is squashed (taken branch).
- `BUS_past` out 16: `BUS` delayed by one cycle.
- `LD_reg_past` out 4: `LD_reg` delayed by one cycle.
- `STALL` out 1: hold fetch/decode and insert a bubble into execute at the next edge.
- `ERR` out 1: sticky timeout flag.
- `STALL_CYCLES` out 16: stall statistics counter (see Configuration).

## Operation
- **History registers:** `BUS_past`/`LD_reg_past` load `BUS`/`LD_reg` every cycle, including stall cycles, because later stages keep advancing.
- **Source decode:** code n (0–3) maps to one-hot `4'b1000>>n`. Codes 4–7 never hazard.
- **Hazard:** `MEM_LD_ex` AND (the Y0 one-hot or the Y1 one-hot equals `LD_reg_ex`) AND `LD_reg_ex`≠0.
- **FSM states:** IDLE, WAIT_MEM, ERROR.
- **IDLE:**
  - `STALL` = hazard AND NOT `FLUSH`, combinational.
  - On that condition: `pend_reg`←`LD_reg_ex`, `cnt`←0, go to WAIT_MEM.
  - `MEM_RDY` is ignored in IDLE, so the minimum stall is 1 cycle.
- **WAIT_MEM:** `done` = `MEM_RDY` AND `LD_reg`==`pend_reg`.
  - `STALL` = NOT `done` AND NOT `FLUSH`.
  - On `done` or `FLUSH`: go to IDLE.
  - Otherwise `cnt`←`cnt`+1. When `cnt`==TIMEOUT−1 and neither `done` nor `FLUSH` holds, go to ERROR.
  - When `done` and `FLUSH` coincide, the result is the same: go to IDLE with `STALL`=0.
- **ERROR:** `STALL`=1 and `ERR`=1 continuously. Exit is only through `RST`; `FLUSH` and `MEM_RDY` are ignored.
- **MEM_RDY mismatch:** `MEM_RDY` with a `LD_reg` that does not match `pend_reg` is not completion; counting continues.
- `pend_reg` is held until the next IDLE→WAIT_MEM transition.

## Timing
- Reset values: `BUS_past`=0, `LD_reg_past`=0, `STALL`=0, `ERR`=0, `STALL_CYCLES`=0, state=IDLE, `cnt`=0, `pend_reg`=0.
- `STALL` is combinational from the current state and inputs. It is valid in the same cycle it applies to, ready for the pipeline registers at the next edge.
- **Completion:** `STALL` falls in the `done` cycle. The dependent instruction leaves decode at that edge, and the next cycle it reads the load result through `BUS_past`.
- **Stall length:** a hazard detected at cycle t with `done` at cycle t+k (k≥1) gives `STALL` high for exactly cycles t..t+k−1.
- **Timeout:** with no completion, `STALL` stays high for TIMEOUT cycles in WAIT_MEM. ERROR is entered after the TIMEOUT-th cycle; `ERR` rises in the next cycle and `STALL` stays high.
- **Mid-operation reset:** `RST` asserted at any point clears everything immediately, without waiting for a clock edge.

## Configuration
- Macro: `HAZARD_STATS_EN`.
- **Defined:** `STALL_CYCLES` increments by 1 on each rising edge where `STALL`=1. It saturates at 16'hFFFF and clears only on `RST`.
- **Undefined:** `STALL_CYCLES` is tied to 16'h0000 and no counter logic is generated.

## Test plan
- **History delay:** `BUS`=16'hA5A5, `LD_reg`=4'd4 at cycle t → `BUS_past`=16'hA5A5 and `LD_reg_past`=4 at t+1, including during a stall.
- **Load-use:** `MEM_LD_ex`=1, `LD_reg_ex`=4'd2, `SEL_id`=6'o02 → `STALL`=1 that cycle. At t+2, `MEM_RDY`=1 with `LD_reg`=2 → `STALL`=0 that cycle, so `STALL` is high for 2 cycles. With `HAZARD_STATS_EN`, `STALL_CYCLES`=2.
- **No hazard:** `SEL_id`=6'o74 (codes 7, 4) with a load in execute → `STALL` stays 0. `MEM_LD_ex`=0 with matching sources → `STALL` stays 0.
- **Wrong completion:** in WAIT_MEM with `pend_reg`=8, `MEM_RDY`=1 and `LD_reg`=1 → `STALL` stays 1. `MEM_RDY`=1 with `LD_reg`=8 → `STALL` drops to 0.
- **Flush:** in WAIT_MEM, `FLUSH`=1 → `STALL`=0 that cycle and state is IDLE next cycle. `FLUSH` coinciding with `done` → same result.
- **Timeout and reset:** TIMEOUT=15 with no `MEM_RDY` → `ERR`=1 after 15 WAIT_MEM cycles and `STALL` held at 1. Async `RST` pulsed mid-cycle → all outputs 0 immediately.
